// File: rtl/char_slot_scheduler_pkg.sv
// Shared types and screen geometry for the falling-character game.
package game_pkg;

   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned CHAR_H   = 16;
   localparam int unsigned NCOL     = 80;

   typedef struct packed {
      logic       valid;
      logic [7:0] ascii;
      logic [6:0] col;
      logic [8:0] y;
      logic [3:0] speed;
   } slot_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOVE  = 2'd1,
      HIT   = 2'd2,
      SPAWN = 2'd3
   } state_t;

endpackage

// File: rtl/char_slot_scheduler_slot_table.sv
// Register array of character slots: one combinational scan/write port for
// the scheduler and one registered read port for the renderer.
module slot_table
   import game_pkg::*;
#(
   parameter int unsigned NSLOT  = 16,
   parameter int unsigned SLOT_W = 4
)(
   input  logic              clkin,
   input  logic              rst,
   input  logic [SLOT_W-1:0] scan_idx,
   output slot_t             scan_data,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_idx,
   input  slot_t             wr_data,
   input  logic [SLOT_W-1:0] rd_slot,
   output slot_t             rd_data
);

   slot_t slots [NSLOT];

   assign scan_data = slots[scan_idx];

   // Table storage and renderer read register (read shows pre-write value).
   always_ff @(posedge clkin) begin
      if (rst) begin
         for (int unsigned i = 0; i < NSLOT; i++) begin
            slots[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         rd_data <= slots[rd_slot];
         if (wr_en) begin
            slots[wr_idx] <= wr_data;
         end
      end
   end

endmodule

// File: rtl/char_slot_scheduler.sv
// Sole writer of the falling-character table: serialises spawn, movement
// tick and keyboard hit requests through a single scan FSM.
module char_slot_scheduler
   import game_pkg::*;
#(
   parameter int unsigned NSLOT  = 16,
   parameter int unsigned SLOT_W = 4
)(
   input  logic              clkin,
   input  logic              rst,
   input  logic              enable,
   input  logic              spawn_valid,
   output logic              spawn_ready,
   input  logic [7:0]        spawn_ascii,
   input  logic [6:0]        spawn_col,
   input  logic [3:0]        spawn_speed,
   input  logic              move_tick,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [7:0]        key_ascii,
   input  logic [SLOT_W-1:0] rd_slot,
   output logic              rd_valid,
   output logic [7:0]        rd_ascii,
   output logic [6:0]        rd_col,
   output logic [8:0]        rd_y,
   output logic [3:0]        rd_speed,
   output logic              hit_pulse,
   output logic              miss_pulse,
   output logic              drop_pulse,
   output logic [15:0]       score,
   output logic [7:0]        misses,
   output logic              busy
);

   localparam logic [9:0]    Y_LIMIT = 10'(SCREEN_H - CHAR_H);
   localparam logic [8:0]    Y_TOP   = 9'(CHAR_H);
   localparam logic [SLOT_W:0] IDX_ONE = (SLOT_W+1)'(1);

   state_t            state;
   logic [SLOT_W:0]   idx;        // idx[SLOT_W] set marks the commit cycle
   logic              tick_pend;
   logic              key_pend;
   logic [7:0]        key_lat;
   logic [7:0]        sp_ascii;
   logic [6:0]        sp_col;
   logic [3:0]        sp_speed;
   logic              best_found;
   logic [SLOT_W-1:0] best_idx;
   logic [8:0]        best_y;
   logic              free_found;
   logic [SLOT_W-1:0] free_idx;
   logic              collide;

   logic [SLOT_W-1:0] scan_sel;
   slot_t             scan_data;
   logic              wr_en;
   logic [SLOT_W-1:0] wr_idx;
   slot_t             wr_data;
   slot_t             rd_data;
   logic [9:0]        y_new;
   logic              miss_now;
   logic              commit;

   slot_table #(
      .NSLOT  (NSLOT),
      .SLOT_W (SLOT_W)
   ) u_table (
      .clkin     (clkin),
      .rst       (rst),
      .scan_idx  (scan_sel),
      .scan_data (scan_data),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .rd_slot   (rd_slot),
      .rd_data   (rd_data)
   );

   assign rd_valid = rd_data.valid;
   assign rd_ascii = rd_data.ascii;
   assign rd_col   = rd_data.col;
   assign rd_y     = rd_data.y;
   assign rd_speed = rd_data.speed;

   assign busy        = (state != IDLE);
   assign key_ready   = enable & ~key_pend & ~rst;
   assign spawn_ready = enable & (state == IDLE) & ~key_pend & ~tick_pend & ~rst;

   assign commit   = idx[SLOT_W];
   assign y_new    = {1'b0, scan_data.y} + {6'd0, scan_data.speed};
   assign miss_now = (state == MOVE) & scan_data.valid & (y_new > Y_LIMIT);

   // Scan address: index order, except the HIT commit revisits the winner.
   always_comb begin
      scan_sel = idx[SLOT_W-1:0];
      if (state == HIT && commit) begin
         scan_sel = best_idx;
      end
   end

   // Table write decisions for the slot currently being scanned/committed.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = scan_sel;
      wr_data = scan_data;
      case (state)
         MOVE: begin
            if (scan_data.valid) begin
               wr_en = 1'b1;
               if (miss_now) begin
                  wr_data.valid = 1'b0;
               end else begin
                  wr_data.y = y_new[8:0];
               end
            end
         end
         HIT: begin
            if (commit && best_found) begin
               wr_en         = 1'b1;
               wr_data.valid = 1'b0;
            end
         end
         SPAWN: begin
            if (commit && free_found && !collide) begin
               wr_en         = 1'b1;
               wr_idx        = free_idx;
               wr_data.valid = 1'b1;
               wr_data.ascii = sp_ascii;
               wr_data.col   = sp_col;
               wr_data.y     = '0;
               wr_data.speed = sp_speed;
            end
         end
         default: ;
      endcase
   end

   // Request latching, dispatch FSM, scan bookkeeping and counters.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         tick_pend  <= 1'b0;
         key_pend   <= 1'b0;
         key_lat    <= '0;
         sp_ascii   <= '0;
         sp_col     <= '0;
         sp_speed   <= '0;
         best_found <= 1'b0;
         best_idx   <= '0;
         best_y     <= '0;
         free_found <= 1'b0;
         free_idx   <= '0;
         collide    <= 1'b0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         drop_pulse <= 1'b0;
         score      <= '0;
         misses     <= '0;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         drop_pulse <= 1'b0;

         if (!enable) begin
            tick_pend <= 1'b0;
            key_pend  <= 1'b0;
         end else begin
            if (move_tick) begin
               tick_pend <= 1'b1;
            end
            if (key_valid && key_ready) begin
               key_pend <= 1'b1;
               key_lat  <= key_ascii;
            end
         end

         // Dispatch clears below are placed after the sets so that a tick
         // arriving in the cycle its pending flag is consumed is dropped.
         case (state)
            IDLE: begin
               idx <= '0;
               if (enable && key_pend) begin
                  state      <= HIT;
                  key_pend   <= 1'b0;
                  best_found <= 1'b0;
                  best_idx   <= '0;
                  best_y     <= '0;
               end else if (enable && tick_pend) begin
                  state     <= MOVE;
                  tick_pend <= 1'b0;
               end else if (spawn_valid && spawn_ready) begin
                  state      <= SPAWN;
                  sp_ascii   <= spawn_ascii;
                  sp_col     <= spawn_col;
                  sp_speed   <= spawn_speed;
                  free_found <= 1'b0;
                  free_idx   <= '0;
                  collide    <= 1'b0;
               end
            end
            MOVE: begin
               if (miss_now) begin
                  miss_pulse <= 1'b1;
                  if (misses != '1) begin
                     misses <= misses + 8'd1;
                  end
               end
               idx <= idx + IDX_ONE;
               if (idx[SLOT_W-1:0] == '1) begin
                  state <= IDLE;
               end
            end
            HIT: begin
               if (!commit) begin
                  if (scan_data.valid && scan_data.ascii == key_lat &&
                      (!best_found || scan_data.y > best_y)) begin
                     best_found <= 1'b1;
                     best_idx   <= idx[SLOT_W-1:0];
                     best_y     <= scan_data.y;
                  end
                  idx <= idx + IDX_ONE;
               end else begin
                  if (best_found) begin
                     hit_pulse <= 1'b1;
                     if (score != '1) begin
                        score <= score + 16'd1;
                     end
                  end
                  state <= IDLE;
               end
            end
            SPAWN: begin
               if (!commit) begin
                  if (!scan_data.valid && !free_found) begin
                     free_found <= 1'b1;
                     free_idx   <= idx[SLOT_W-1:0];
                  end
                  if (scan_data.valid && scan_data.col == sp_col && scan_data.y < Y_TOP) begin
                     collide <= 1'b1;
                  end
                  idx <= idx + IDX_ONE;
               end else begin
                  if (!free_found || collide) begin
                     drop_pulse <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
